// File: rtl/pwm_chk_pkg.sv
// Shared types and helpers for the PWM duty-cycle checker.
package pwm_chk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_MEASURE = 3'd1,
      ST_EVAL    = 3'd2,
      ST_PASS    = 3'd3,
      ST_FAIL    = 3'd4
   } state_e;

   // True when |meas - expv| <= tol; the difference is taken larger-minus-smaller so it never wraps.
   function automatic logic within_tol(input logic [31:0] meas,
                                       input logic [31:0] expv,
                                       input logic [31:0] tol);
      logic [31:0] diff;
      diff = (meas >= expv) ? (meas - expv) : (expv - meas);
      return (diff <= tol);
   endfunction

endpackage : pwm_chk_pkg

// File: rtl/pwm_duty_checker_if.sv
// Control, PWM inputs and result bus of the PWM duty-cycle checker.
interface pwm_duty_checker_if #(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned PERIOD_W = 11
);
   logic                             start;
   logic                             abort;
   logic [NUM_CH-1:0]                pwm;
   logic [NUM_CH*PERIOD_W-1:0]       exp_duty;
   logic                             busy;
   logic                             done;
   logic                             pass;
   logic                             timeout;
   logic [NUM_CH-1:0]                fail_mask;
   logic [NUM_CH*(PERIOD_W+1)-1:0]   meas_duty;

   modport master (
      output start, abort, pwm, exp_duty,
      input  busy, done, pass, timeout, fail_mask, meas_duty
   );

   modport slave (
      input  start, abort, pwm, exp_duty,
      output busy, done, pass, timeout, fail_mask, meas_duty
   );
endinterface : pwm_duty_checker_if

// File: rtl/pwm_duty_counter.sv
// Per-channel high-time counter, tolerance match and consecutive-match streak.
module pwm_duty_counter
   import pwm_chk_pkg::*;
#(
   parameter int unsigned PERIOD_W      = 11,
   parameter int unsigned TOL           = 8,
   parameter int unsigned MATCH_WINDOWS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_clear,
   input  logic                i_sample,
   input  logic                i_eval,
   input  logic                i_pwm,
   input  logic [PERIOD_W-1:0] i_exp,
   output logic [PERIOD_W:0]   o_count,
   output logic                o_full,
   output logic                o_eval_full_c
);

   localparam int unsigned STREAK_W = $clog2(MATCH_WINDOWS + 1);

   logic [PERIOD_W:0]   r_count;
   logic [STREAK_W-1:0] r_streak;
   logic                w_match;

   assign w_match       = within_tol(32'(r_count), 32'(i_exp), 32'(TOL));
   assign o_count       = r_count;
   assign o_full        = (r_streak == STREAK_W'(MATCH_WINDOWS));
   // Streak will be full after this EVAL: matching now and already one short (or saturated).
   assign o_eval_full_c = w_match && (r_streak >= STREAK_W'(MATCH_WINDOWS - 1));

   // Count high cycles during MEASURE; on EVAL update the streak and restart the window.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= '0;
         r_streak <= '0;
      end else if (i_clear) begin
         r_count  <= '0;
         r_streak <= '0;
      end else if (i_eval) begin
         r_count <= '0;
         if (!w_match)
            r_streak <= '0;
         else if (r_streak != STREAK_W'(MATCH_WINDOWS))
            r_streak <= r_streak + 1'b1;
      end else if (i_sample && i_pwm) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule : pwm_duty_counter

// File: rtl/pwm_duty_checker.sv
// Multi-channel PWM duty-cycle monitor: windowed measurement, streak-based pass, watchdog timeout.
module pwm_duty_checker
   import pwm_chk_pkg::*;
#(
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned PERIOD_W      = 11,
   parameter int unsigned TOL           = 8,
   parameter int unsigned MATCH_WINDOWS = 2,
   parameter int unsigned TIMEOUT_CYC   = 500000
) (
   input  logic               clk,
   input  logic               rst,
   pwm_duty_checker_if.slave  bus
);

   localparam int unsigned PERIOD = 2 ** PERIOD_W;
   localparam int unsigned WD_W   = $clog2(TIMEOUT_CYC + 1);

   state_e                          r_state;
   logic [PERIOD_W-1:0]             r_cyc;
   logic [WD_W-1:0]                 r_wd;
   logic [NUM_CH*PERIOD_W-1:0]      r_exp;
   logic                            r_busy;
   logic                            r_done;
   logic                            r_pass;
   logic                            r_timeout;
   logic [NUM_CH-1:0]               r_fail_mask;
   logic [NUM_CH*(PERIOD_W+1)-1:0]  r_meas;

   logic                            w_start;
   logic                            w_sample;
   logic                            w_eval;
   logic                            w_wd_hit;
   logic [NUM_CH-1:0]               w_full;
   logic [NUM_CH-1:0]               w_eval_full;
   logic [NUM_CH*(PERIOD_W+1)-1:0]  w_count;

   assign w_start  = (r_state == ST_IDLE) && bus.start && !bus.abort;
   assign w_sample = (r_state == ST_MEASURE) && !bus.abort;
   assign w_eval   = (r_state == ST_EVAL) && !bus.abort;
   // Watchdog reaches TIMEOUT_CYC on the edge that completes the TIMEOUT_CYC-th busy cycle.
   assign w_wd_hit = (r_wd == WD_W'(TIMEOUT_CYC - 1));

   // One counter/streak slice per channel.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      pwm_duty_counter #(
         .PERIOD_W      (PERIOD_W),
         .TOL           (TOL),
         .MATCH_WINDOWS (MATCH_WINDOWS)
      ) u_cnt (
         .clk           (clk),
         .rst           (rst),
         .i_clear       (w_start),
         .i_sample      (w_sample),
         .i_eval        (w_eval),
         .i_pwm         (bus.pwm[g]),
         .i_exp         (r_exp[g*PERIOD_W +: PERIOD_W]),
         .o_count       (w_count[g*(PERIOD_W+1) +: (PERIOD_W+1)]),
         .o_full        (w_full[g]),
         .o_eval_full_c (w_eval_full[g])
      );
   end

   // Control FSM, window timer, watchdog and registered results; abort overrides all but rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cyc       <= '0;
         r_wd        <= '0;
         r_exp       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_timeout   <= 1'b0;
         r_fail_mask <= '0;
         r_meas      <= '0;
      end else begin
         r_done <= 1'b0;
         if (bus.abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_start) begin
                     r_exp       <= bus.exp_duty;
                     r_pass      <= 1'b0;
                     r_timeout   <= 1'b0;
                     r_fail_mask <= '0;
                     r_wd        <= '0;
                     r_cyc       <= '0;
                     r_busy      <= 1'b1;
                     r_state     <= ST_MEASURE;
                  end
               end
               ST_MEASURE: begin
                  r_wd  <= r_wd + 1'b1;
                  r_cyc <= r_cyc + 1'b1;
                  if (w_wd_hit)
                     r_state <= ST_FAIL;
                  else if (r_cyc == PERIOD_W'(PERIOD - 1))
                     r_state <= ST_EVAL;
               end
               ST_EVAL: begin
                  r_wd   <= r_wd + 1'b1;
                  r_cyc  <= '0;
                  r_meas <= w_count;
                  if (&w_eval_full)
                     r_state <= ST_PASS;
                  else if (w_wd_hit)
                     r_state <= ST_FAIL;
                  else
                     r_state <= ST_MEASURE;
               end
               ST_PASS: begin
                  r_done  <= 1'b1;
                  r_pass  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
               ST_FAIL: begin
                  r_done      <= 1'b1;
                  r_timeout   <= 1'b1;
                  r_fail_mask <= ~w_full;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
               default: begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.pass      = r_pass;
   assign bus.timeout   = r_timeout;
   assign bus.fail_mask = r_fail_mask;
   assign bus.meas_duty = r_meas;

endmodule : pwm_duty_checker

// File: tb/tb_pwm_duty_checker.sv
// Directed scoreboard bench for pwm_duty_checker (two instances: general and short watchdog).
module tb_pwm_duty_checker;

   localparam int unsigned NCH  = 4;
   localparam int unsigned PW   = 11;
   localparam int          WIN  = 2049;  // MEASURE + EVAL cycles per window

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pwm_duty_checker_if #(.NUM_CH(NCH), .PERIOD_W(PW)) bus ();
   pwm_duty_checker_if #(.NUM_CH(NCH), .PERIOD_W(PW)) if6 ();

   pwm_duty_checker #(.TIMEOUT_CYC(10000)) u_dut (
      .clk (clk), .rst (rst), .bus (bus)
   );
   pwm_duty_checker #(.TIMEOUT_CYC(4098)) u_dut6 (
      .clk (clk), .rst (rst), .bus (if6)
   );

   typedef struct {
      int          lat;
      logic        pass;
      logic        tmo;
      logic [3:0]  mask;
      logic [47:0] meas;
   } sb_t;

   sb_t   sb_q[$];
   string tag_q[$];

   int n_chk, n_pass, n_fail;
   int cyc, t0;
   logic gen_on;
   logic sel;
   int hi_tab [8][4];

   logic        o_busy, o_done, o_pass, o_tmo;
   logic [3:0]  o_mask;
   logic [47:0] o_meas;

   // Observe whichever instance is under test.
   always_comb begin
      o_busy = sel ? if6.busy      : bus.busy;
      o_done = sel ? if6.done      : bus.done;
      o_pass = sel ? if6.pass      : bus.pass;
      o_tmo  = sel ? if6.timeout   : bus.timeout;
      o_mask = sel ? if6.fail_mask : bus.fail_mask;
      o_meas = sel ? if6.meas_duty : bus.meas_duty;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // PWM generator aligned to the last accepted start: window w sample ph is high when ph < hi_tab[w][ch].
   always @(negedge clk) begin
      logic [3:0] v;
      int rel, win, ph;
      v = '0;
      if (gen_on) begin
         rel = cyc - t0;
         win = rel / WIN;
         if (win > 7) win = 7;
         ph = rel % WIN;
         for (int c = 0; c < 4; c++) v[c] = (ph < 2048) && (ph < hi_tab[win][c]);
      end
      bus.pwm = v;
      if6.pwm = v;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic set_exp(input int e0, input int e1, input int e2, input int e3);
      bus.exp_duty = {11'(e3), 11'(e2), 11'(e1), 11'(e0)};
      if6.exp_duty = bus.exp_duty;
   endtask

   task automatic set_hi(input int ch, input int val);
      for (int w = 0; w < 8; w++) hi_tab[w][ch] = val;
   endtask

   task automatic expect_run(input string tag, input int lat, input logic p, input logic t,
                             input logic [3:0] mask, input int m0, input int m1, input int m2, input int m3);
      sb_t e;
      e.lat  = lat;
      e.pass = p;
      e.tmo  = t;
      e.mask = mask;
      e.meas = {12'(m3), 12'(m2), 12'(m1), 12'(m0)};
      sb_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic do_start(input logic s);
      @(negedge clk);
      sel = s;
      if (s) if6.start = 1'b1; else bus.start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      bus.start = 1'b0;
      if6.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output logic seen, output int lat);
      seen = 1'b0;
      lat  = 0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (o_done) begin
            seen = 1'b1;
            lat  = cyc - t0;
         end
      end
   endtask

   task automatic collect(input int budget);
      logic  seen;
      int    lat;
      sb_t   e;
      string tag;
      wait_done(budget, seen, lat);
      e   = sb_q.pop_front();
      tag = tag_q.pop_front();
      chk({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
         chk({tag, "_busy"},    64'(o_busy), 64'd0);
         chk({tag, "_pass"},    64'(o_pass), 64'(e.pass));
         chk({tag, "_timeout"}, 64'(o_tmo),  64'(e.tmo));
         chk({tag, "_mask"},    64'(o_mask), 64'(e.mask));
         chk({tag, "_meas"},    64'(o_meas), 64'(e.meas));
      end
   endtask

   initial begin
      logic seen;
      int   lat;
      n_chk = 0; n_pass = 0; n_fail = 0;
      t0 = 0; gen_on = 1'b0; sel = 1'b0; rst = 1'b1;
      bus.start = 1'b0; bus.abort = 1'b0;
      if6.start = 1'b0; if6.abort = 1'b0;
      set_exp(1024, 1024, 1024, 1024);
      for (int c = 0; c < 4; c++) set_hi(c, 1024);

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_done", 64'(o_done), 64'd0);
      chk("rst_pass", 64'(o_pass), 64'd0);
      chk("rst_timeout", 64'(o_tmo), 64'd0);
      chk("rst_mask", 64'(o_mask), 64'd0);
      chk("rst_meas", 64'(o_meas), 64'd0);
      gen_on = 1'b1;

      // Nominal 50% on every channel
      expect_run("t1_nominal", 4099, 1'b1, 1'b0, 4'b0000, 1024, 1024, 1024, 1024);
      do_start(1'b0);
      collect(4200);

      // Ch2 16 cycles high: never matches, watchdog expires
      set_hi(2, 1040);
      expect_run("t2_ch2_high", 10001, 1'b0, 1'b1, 4'b0100, 1024, 1024, 1040, 1024);
      do_start(1'b0);
      collect(10100);
      set_hi(2, 1024);

      // Ch1 exactly at tolerance passes; one beyond times out
      set_hi(1, 1032);
      expect_run("t3_tol_edge", 4099, 1'b1, 1'b0, 4'b0000, 1024, 1032, 1024, 1024);
      do_start(1'b0);
      collect(4200);
      set_hi(1, 1033);
      expect_run("t3_tol_over", 10001, 1'b0, 1'b1, 4'b0010, 1024, 1033, 1024, 1024);
      do_start(1'b0);
      collect(10100);
      set_hi(1, 1024);

      // Ch0 glitch in window 2 resets its streak
      hi_tab[1][0] = 900;
      expect_run("t4_streak_reset", 8197, 1'b1, 1'b0, 4'b0000, 1024, 1024, 1024, 1024);
      do_start(1'b0);
      collect(8300);
      set_hi(0, 1024);

      // Reset mid-MEASURE discards progress, no done follows
      do_start(1'b0);
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_rst_busy", 64'(o_busy), 64'd0);
      chk("t5_rst_done", 64'(o_done), 64'd0);
      chk("t5_rst_pass", 64'(o_pass), 64'd0);
      chk("t5_rst_timeout", 64'(o_tmo), 64'd0);
      chk("t5_rst_mask", 64'(o_mask), 64'd0);
      chk("t5_rst_meas", 64'(o_meas), 64'd0);
      wait_done(4200, seen, lat);
      chk("t5_rst_no_done", 64'(seen), 64'd0);

      // Abort mid-check: idle next cycle, no done
      do_start(1'b0);
      repeat (500) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("t5_abort_busy", 64'(o_busy), 64'd0);
      wait_done(4200, seen, lat);
      chk("t5_abort_no_done", 64'(seen), 64'd0);

      // Start and exp_duty change while busy are ignored
      expect_run("t5_start_busy", 4099, 1'b1, 1'b0, 4'b0000, 1024, 1024, 1024, 1024);
      do_start(1'b0);
      repeat (1000) @(negedge clk);
      set_exp(256, 256, 256, 256);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("t5_busy_kept", 64'(o_busy), 64'd1);
      collect(3200);
      set_exp(1024, 1024, 1024, 1024);

      // Boundaries: exp=0 constant low, constant high vs PERIOD-1 and PERIOD-8, low side at TOL
      set_exp(0, 2047, 2040, 8);
      set_hi(0, 0); set_hi(1, 2048); set_hi(2, 2048); set_hi(3, 0);
      expect_run("t7_bounds", 4099, 1'b1, 1'b0, 4'b0000, 0, 2048, 2048, 0);
      do_start(1'b0);
      collect(4200);
      set_exp(1024, 1024, 1024, 1024);
      for (int c = 0; c < 4; c++) set_hi(c, 1024);

      // Watchdog expiring on the all-pass EVAL: PASS wins
      expect_run("t6_pass_wins", 4099, 1'b1, 1'b0, 4'b0000, 1024, 1024, 1024, 1024);
      do_start(1'b1);
      collect(4200);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_pwm_duty_checker

// File: doc/pwm_duty_checker.md
Name: pwm_duty_checker

Overview:
Synthesizable multi-channel PWM duty-cycle monitor, the successor to ad-hoc single-shot PWM value checks in the Knight's Tour benches. It measures the high-time of N PWM channels over fixed windows and compares each result against a per-channel expected duty with tolerance. A channel passes after a number of consecutive matching windows; a watchdog flags a timeout. It is used in benches and in on-chip self-test next to the motor drive.

Parameters:
NUM_CH, 4, number of PWM channels monitored
PERIOD_W, 11, duty width; window length PERIOD = 2**PERIOD_W cycles
TOL, 8, allowed absolute error in cycles, inclusive
MATCH_WINDOWS, 2, consecutive matching windows required per channel (>=1)
TIMEOUT_CYC, 500000, cycles from start to declare timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin check; ignored unless idle
abort  in  1  return to idle, no done pulse
pwm  in  NUM_CH  PWM inputs, synchronous to clk
exp_duty  in  NUM_CH*PERIOD_W  expected high cycles per channel (ch0 in LSBs); latched at start
busy  out  1  check in progress
done  out  1  one-cycle pulse on completion
pass  out  1  all channels matched; held until next start
timeout  out  1  watchdog expired; held until next start
fail_mask  out  NUM_CH  bit i set if channel i had not reached its streak at timeout
meas_duty  out  NUM_CH*(PERIOD_W+1)  high-cycle counts of the last completed window

Behaviour:
- Reset: state IDLE; busy, done, pass, timeout, fail_mask, meas_duty and all counters are 0. Reset mid-check discards all progress.
- FSM states: IDLE, MEASURE, EVAL, PASS, FAIL.
- IDLE: start=1 latches exp_duty, clears pass/timeout/fail_mask/streaks/watchdog, clears window counters, and moves to MEASURE. busy=1 from the next cycle.
- MEASURE: exactly PERIOD cycles. Each channel counter increments when pwm[i]=1. The counter is PERIOD_W+1 bits (range 0..PERIOD). Then EVAL.
- EVAL (1 cycle; pwm is not sampled):
  - meas_duty <= counts.
  - Channel i matches when |count - exp| <= TOL. Compute the difference unsigned, extended to PERIOD_W+1 bits; no wrap.
  - On a match, streak[i] increments and saturates at MATCH_WINDOWS. On a mismatch, streak[i] resets to 0.
  - If every streak reaches MATCH_WINDOWS, go to PASS. Otherwise clear the counters and return to MEASURE.
- Watchdog: counts every busy cycle. When it reaches TIMEOUT_CYC, go to FAIL with timeout=1 and fail_mask[i] = (streak[i] < MATCH_WINDOWS).
- Simultaneous events:
  - If the watchdog expires in the same cycle as an all-pass EVAL, PASS wins.
  - abort has priority over everything except rst.
- PASS/FAIL: done=1 for one cycle, busy=0, then IDLE. pass=1 only via PASS. Results are held until the next start.
- Latency for a steady matching waveform: done asserted MATCH_WINDOWS*(PERIOD+1)+1 cycles after the start cycle (4099 at defaults).
- Boundaries:
  - exp=0 with a constant-low input matches.
  - A constant-high input yields count=PERIOD. It matches exp=PERIOD-1 only if TOL>=1.
  - start while busy is ignored.
  - exp_duty changes while busy have no effect.

Decomposition:
- Shared package pwm_chk_pkg holds the FSM state enum and the abs-difference/tolerance compare function.
- One sub-module, pwm_duty_counter (per-channel window counter, match logic and streak), instantiated NUM_CH times via generate.
- The top level holds the FSM, the watchdog and output registers.

Test Plan:
1. Defaults; all channels driven at exactly 1024 of 2048 high; exp=0x400 each; start -> done at cycle 4099, pass=1, timeout=0, meas_duty=1024 each.
2. Ch2 driven at 1040, exp 0x400, TOL=8 -> never matches; at TIMEOUT_CYC: done, pass=0, timeout=1, fail_mask=4'b0100, meas_duty[ch2]=1040.
3. Ch1 at 1032 (diff exactly 8) -> pass at 4099; then rerun with 1033 -> times out with fail_mask=4'b0010.
4. Ch0 matches window 1, glitches to 900 in window 2, then matches windows 3–4 -> streak resets; done at 4*(2049)+1=8197, pass=1.
5. Mid-MEASURE: assert rst one cycle -> next cycle busy=0, all outputs 0. Separately pulse abort -> IDLE, no done. A start while busy is ignored and the latched exp is unchanged.
6. TIMEOUT_CYC=4098 with a waveform that passes in the EVAL at cycle 4098 -> PASS wins: pass=1, timeout=0.
